// File: rtl/dm_access_pkg.sv
// Shared definitions for the data-memory access sequencer: access-size codes,
// sequencer states and the access-legality check.
package dm_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        LOAD  = 3'd2,
        MERGE = 3'd3,
        WR    = 3'd4,
        ERR   = 3'd5
    } state_t;

    // True when the access must be rejected without touching memory.
    function automatic logic acc_error(input logic [1:0]  sz,
                                       input logic [11:0] a,
                                       input int unsigned depth);
        logic bad;
        bad = 1'b0;
        if (sz == SZ_RSVD)
            bad = 1'b1;
        if ((sz == SZ_HALF) && a[0])
            bad = 1'b1;
        if ((sz == SZ_WORD) && (a[1:0] != 2'b00))
            bad = 1'b1;
        if ({22'd0, a[11:2]} >= depth)
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Combinational big-endian lane logic: inserts store data into a memory word
// and extracts/extends load data from it (byte 0 = [31:24], half 0 = [31:16]).
module dm_lane_merge
    import dm_access_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_wdata,
    input  logic        i_uns,
    output logic [31:0] o_merged,
    output logic [31:0] o_load
);

    logic [3:0] w_lane_sel;
    logic [7:0] w_lane_wbyte [4];
    logic [7:0] w_lane_rbyte [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam int         HI   = 31 - 8 * gi;
            localparam logic [1:0] LANE = 2'(gi);

            assign w_lane_sel[gi] = (i_size == SZ_BYTE) ? (i_offset == LANE) :
                                    (i_size == SZ_HALF) ? (i_offset[1] == LANE[1]) :
                                                          1'b1;

            // Sub-word store data arrives right-aligned; route it to this lane.
            assign w_lane_wbyte[gi] = (i_size == SZ_BYTE) ? i_wdata[7:0] :
                                      (i_size == SZ_HALF) ? (LANE[0] ? i_wdata[7:0] : i_wdata[15:8]) :
                                                            i_wdata[HI -: 8];

            assign o_merged[HI -: 8] = w_lane_sel[gi] ? w_lane_wbyte[gi] : i_word[HI -: 8];
            assign w_lane_rbyte[gi]  = i_word[HI -: 8];
        end
    endgenerate

    assign w_byte = w_lane_rbyte[i_offset];
    assign w_half = i_offset[1] ? i_word[15:0] : i_word[31:16];

    always_comb begin
        o_load = i_word;
        case (i_size)
            SZ_BYTE: o_load = {{24{~i_uns & w_byte[7]}}, w_byte};
            SZ_HALF: o_load = {{16{~i_uns & w_half[15]}}, w_half};
            default: o_load = i_word;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store sequencer in front of a word-only single-port data memory:
// sub-word stores become read-modify-write, sub-word loads are extracted.
module dm_access_ctrl
    import dm_access_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [11:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic        dm_dmwr,
    output logic        dm_wren,
    output logic [9:0]  dm_address,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);

    state_t      r_state;
    state_t      w_state_next;
    logic        w_capture;
    logic        w_ack_next;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [1:0]  r_offset;
    logic [31:0] r_wdata;

    logic        r_ack;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_dmwr;
    logic [9:0]  r_address;
    logic [31:0] r_din;

    logic [31:0] w_merged;
    logic [31:0] w_load;

    dm_lane_merge u_lane_merge (
        .i_word   (dm_dout),
        .i_offset (r_offset),
        .i_size   (r_size),
        .i_wdata  (r_wdata),
        .i_uns    (r_uns),
        .o_merged (w_merged),
        .o_load   (w_load)
    );

    assign w_capture = (r_state == IDLE) && req;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (acc_error(size, addr, DEPTH_WORDS))
                        w_state_next = ERR;
                    else if (we && (size == SZ_WORD))
                        w_state_next = WR;
                    else
                        w_state_next = RD;
                end
            end
            RD:      w_state_next = r_we ? MERGE : LOAD;
            MERGE:   w_state_next = WR;
            LOAD:    w_state_next = IDLE;
            WR:      w_state_next = IDLE;
            ERR:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        w_ack_next = (w_state_next == LOAD) || (w_state_next == WR) || (w_state_next == ERR);
    end

    // Outputs are loaded from the next state so they are clean registers
    // that are asserted exactly while the matching state is current.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_dmwr    <= 1'b0;
            r_address <= '0;
            r_din     <= '0;
            r_we      <= 1'b0;
            r_size    <= SZ_BYTE;
            r_uns     <= 1'b0;
            r_offset  <= '0;
            r_wdata   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_ack_next;
            r_err   <= (w_state_next == ERR);
            r_dmwr  <= (w_state_next == WR);

            if (w_capture) begin
                r_we     <= we;
                r_size   <= size;
                r_uns    <= uns;
                r_offset <= addr[1:0];
                r_wdata  <= wdata;
            end

            if (w_capture && (w_state_next != ERR))
                r_address <= addr[11:2];

            if (w_capture && (w_state_next == WR))
                r_din <= wdata;
            else if (r_state == MERGE)
                r_din <= w_merged;

            if (r_state == LOAD)
                r_rdata <= w_load;
        end
    end

    // Memory read data is only valid in LOAD, so the load result bypasses the
    // holding register in that cycle.
    assign rdata      = (r_state == LOAD) ? w_load : r_rdata;
    assign ack        = r_ack;
    assign err        = r_err;
    assign dm_dmwr    = r_dmwr;
    assign dm_wren    = r_dmwr;
    assign dm_address = r_address;
    assign dm_din     = r_din;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed vector table, hand-written
// reset/handshake sequences and randomized accesses against a word-array model.
`timescale 1ns/1ps
module tb_dm_access_ctrl;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        dm_dmwr;
    logic        dm_wren;
    logic [9:0]  dm_address;
    logic [31:0] dm_din;
    logic [31:0] dm_dout;

    int n_cmp = 0;
    int n_bad = 0;
    int wren_bad = 0;

    logic [31:0] mem [0:1023] = '{default: 32'h0};
    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] ref_rdata;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rdata;
        int          mem_idx;
        logic [31:0] mem_exp;
    } vec_t;

    vec_t vecs [16];

    dm_access_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .size       (size),
        .uns        (uns),
        .addr       (addr),
        .wdata      (wdata),
        .ack        (ack),
        .err        (err),
        .rdata      (rdata),
        .dm_dmwr    (dm_dmwr),
        .dm_wren    (dm_wren),
        .dm_address (dm_address),
        .dm_din     (dm_din),
        .dm_dout    (dm_dout)
    );

    always #5 clk = ~clk;

    // Single-port memory with registered read.
    always @(posedge clk) begin
        if (dm_wren)
            mem[dm_address] <= dm_din;
        dm_dout <= mem[dm_address];
    end

    always @(negedge clk) begin
        if (dm_wren !== dm_dmwr)
            wren_bad++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // Reference model: memory as a word array, lanes by shift/mask arithmetic.
    task automatic model(input logic m_we, input logic [1:0] m_size, input logic m_uns,
                         input logic [11:0] m_addr, input logic [31:0] m_wdata,
                         output logic e_err, output int e_lat, output logic [31:0] e_rdata,
                         output int e_wr);
        int a, off, idx, nbytes, sh;
        longint unsigned mask, w, v;
        a   = int'(m_addr);
        off = a % 4;
        idx = a / 4;
        e_wr = 0;
        if (m_size == 2'd3) begin
            e_err = 1'b1;
            nbytes = 0;
        end else begin
            nbytes = 1 << m_size;
            e_err = (idx >= DEPTH) || ((off % nbytes) != 0);
        end
        if (e_err) begin
            e_lat = 1;
        end else begin
            sh   = 8 * (4 - nbytes - off);
            mask = (64'd1 << (8 * nbytes)) - 64'd1;
            w    = 64'(ref_mem[idx]);
            if (m_we) begin
                w = (w & ~(mask << sh)) | ((64'(m_wdata) & mask) << sh);
                ref_mem[idx] = w[31:0];
                e_lat = (nbytes == 4) ? 1 : 3;
                e_wr  = 1;
            end else begin
                v = (w >> sh) & mask;
                if (!m_uns && (nbytes < 4) && (((v >> (8 * nbytes - 1)) & 64'd1) != 0))
                    v = v | ~mask;
                ref_rdata = v[31:0];
                e_lat = 2;
            end
        end
        e_rdata = ref_rdata;
    endtask

    // One access: req is dropped and the other inputs scrambled right after capture.
    task automatic access(input logic a_we, input logic [1:0] a_size, input logic a_uns,
                          input logic [11:0] a_addr, input logic [31:0] a_wdata,
                          output int lat, output logic g_err, output logic [31:0] g_rdata,
                          output int n_ack, output int n_wr, output int wr_cyc,
                          output logic [9:0] wr_addr);
        @(negedge clk);
        req = 1'b1; we = a_we; size = a_size; uns = a_uns; addr = a_addr; wdata = a_wdata;
        lat = 0; g_err = 1'b0; g_rdata = '0; n_ack = 0; n_wr = 0; wr_cyc = 0; wr_addr = '0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (ack) begin
                n_ack++;
                if (lat == 0) begin
                    lat = k; g_err = err; g_rdata = rdata;
                end
            end
            if (dm_dmwr) begin
                n_wr++; wr_cyc = k; wr_addr = dm_address;
            end
            if (k == 1) begin
                req = 1'b0; we = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
                addr = 12'($urandom); wdata = $urandom;
            end
        end
    endtask

    task automatic run_model_txn(input string tag, input logic t_we, input logic [1:0] t_size,
                                 input logic t_uns, input logic [11:0] t_addr, input logic [31:0] t_wdata);
        logic e_err, g_err;
        int e_lat, e_wr, lat, n_ack, n_wr, wr_cyc;
        logic [31:0] e_rdata, g_rdata;
        logic [9:0] wr_addr;
        model(t_we, t_size, t_uns, t_addr, t_wdata, e_err, e_lat, e_rdata, e_wr);
        access(t_we, t_size, t_uns, t_addr, t_wdata, lat, g_err, g_rdata, n_ack, n_wr, wr_cyc, wr_addr);
        chk({tag, " err"}, 32'(g_err), 32'(e_err));
        chk({tag, " latency"}, 32'(lat), 32'(e_lat));
        chk({tag, " rdata"}, g_rdata, e_rdata);
        chk({tag, " ack count"}, 32'(n_ack), 32'd1);
        chk({tag, " write count"}, 32'(n_wr), 32'(e_wr));
        if (e_wr != 0) begin
            chk({tag, " write cycle"}, 32'(wr_cyc), 32'(e_lat));
            chk({tag, " write addr"}, 32'(wr_addr), 32'(t_addr[11:2]));
        end
        $display("txn %s we=%0d sz=%0d uns=%0d addr=%03h wdata=%08h -> ack@%0d err=%0d rdata=%08h",
                 tag, t_we, t_size, t_uns, t_addr, t_wdata, lat, g_err, g_rdata);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic e_err_d, g_err;
        int e_lat_d, e_wr_d, lat, n_ack, n_wr, wr_cyc;
        logic [31:0] e_rd_d, g_rdata;
        logic [9:0] wr_addr;
        int ack_c [2];
        int na, nw;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0, 1, 32'h00000000, 4,  32'hDEADBEEF};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 12'h010, 32'h0,        1'b0, 2, 32'hDEADBEEF, -1, 32'h0};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 12'h013, 32'h123456A5, 1'b0, 3, 32'hDEADBEEF, 4,  32'hDEADBEA5};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 12'h013, 32'h0,        1'b0, 2, 32'hFFFFFFA5, -1, 32'h0};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 12'h013, 32'h0,        1'b0, 2, 32'h000000A5, -1, 32'h0};
        vecs[5]  = '{1'b1, 2'd1, 1'b0, 12'h010, 32'hABCD1234, 1'b0, 3, 32'h000000A5, 4,  32'h1234BEA5};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 12'h012, 32'h0,        1'b0, 2, 32'hFFFFBEA5, -1, 32'h0};
        vecs[7]  = '{1'b0, 2'd1, 1'b1, 12'h010, 32'h0,        1'b0, 2, 32'h00001234, -1, 32'h0};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 12'h012, 32'h0,        1'b1, 1, 32'h00001234, -1, 32'h0};
        vecs[9]  = '{1'b1, 2'd1, 1'b0, 12'h011, 32'h0000FFFF, 1'b1, 1, 32'h00001234, 4,  32'h1234BEA5};
        vecs[10] = '{1'b1, 2'd2, 1'b0, 12'h080, 32'hCAFEF00D, 1'b1, 1, 32'h00001234, 32, 32'h0};
        vecs[11] = '{1'b0, 2'd3, 1'b0, 12'h010, 32'h0,        1'b1, 1, 32'h00001234, -1, 32'h0};
        vecs[12] = '{1'b0, 2'd0, 1'b1, 12'h011, 32'h0,        1'b0, 2, 32'h00000034, -1, 32'h0};
        vecs[13] = '{1'b0, 2'd0, 1'b0, 12'h07F, 32'h0,        1'b0, 2, 32'h00000000, -1, 32'h0};
        vecs[14] = '{1'b1, 2'd2, 1'b0, 12'h014, 32'h55667788, 1'b0, 1, 32'h00000000, 5,  32'h55667788};
        vecs[15] = '{1'b1, 2'd3, 1'b0, 12'h014, 32'h0,        1'b1, 1, 32'h00000000, 5,  32'h55667788};

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        ref_rdata = 32'h0;

        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset ack", 32'(ack), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset dm_dmwr", 32'(dm_dmwr), 32'd0);
        chk("reset dm_wren", 32'(dm_wren), 32'd0);
        chk("reset dm_address", 32'(dm_address), 32'd0);
        chk("reset dm_din", dm_din, 32'd0);

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            model(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                  e_err_d, e_lat_d, e_rd_d, e_wr_d);
            access(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   lat, g_err, g_rdata, n_ack, n_wr, wr_cyc, wr_addr);
            chk($sformatf("vec%0d err", i), 32'(g_err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d rdata", i), g_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d ack count", i), 32'(n_ack), 32'd1);
            chk($sformatf("vec%0d write count", i), 32'(n_wr),
                32'((vecs[i].we && !vecs[i].exp_err) ? 1 : 0));
            if (n_wr != 0) begin
                chk($sformatf("vec%0d write cycle", i), 32'(wr_cyc), 32'(vecs[i].exp_lat));
                chk($sformatf("vec%0d write addr", i), 32'(wr_addr), 32'(vecs[i].addr[11:2]));
            end
            if (vecs[i].mem_idx >= 0)
                chk($sformatf("vec%0d mem word", i), mem[vecs[i].mem_idx], vecs[i].mem_exp);
            $display("txn vec%0d we=%0d sz=%0d uns=%0d addr=%03h wdata=%08h -> ack@%0d err=%0d rdata=%08h",
                     i, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                     lat, g_err, g_rdata);
        end

        // Reset during MERGE of a byte store: no write, no ack.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd0; uns = 1'b0; addr = 12'h014; wdata = 32'h000000EE;
        na = 0; nw = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (ack) na++;
            if (dm_dmwr) nw++;
            if (k == 1) req = 1'b0;
            if (k == 2) rst = 1'b1;
            if (k == 3) rst = 1'b0;
        end
        ref_rdata = 32'h0;
        chk("abort ack count", 32'(na), 32'd0);
        chk("abort write count", 32'(nw), 32'd0);
        chk("abort mem word5", mem[5], 32'h55667788);
        chk("abort rdata reset", rdata, 32'h0);
        $display("txn abort sb addr=014 -> acks=%0d writes=%0d", na, nw);
        run_model_txn("post-abort lw", 1'b0, 2'd2, 1'b0, 12'h014, 32'h0);

        // Held req across two word stores, inputs switched after the first ack.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd2; uns = 1'b0; addr = 12'h000; wdata = 32'h1;
        na = 0; nw = 0; ack_c[0] = 0; ack_c[1] = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (dm_dmwr) nw++;
            if (ack) begin
                if (na < 2) ack_c[na] = k;
                na++;
                if (na == 1) begin addr = 12'h004; wdata = 32'h2; end
                else req = 1'b0;
            end
        end
        req = 1'b0;
        model(1'b1, 2'd2, 1'b0, 12'h000, 32'h1, e_err_d, e_lat_d, e_rd_d, e_wr_d);
        model(1'b1, 2'd2, 1'b0, 12'h004, 32'h2, e_err_d, e_lat_d, e_rd_d, e_wr_d);
        chk("b2b ack count", 32'(na), 32'd2);
        chk("b2b first ack cycle", 32'(ack_c[0]), 32'd1);
        chk("b2b second ack cycle", 32'(ack_c[1]), 32'd3);
        chk("b2b write count", 32'(nw), 32'd2);
        chk("b2b mem word0", mem[0], 32'h1);
        chk("b2b mem word1", mem[1], 32'h2);
        $display("txn b2b sw x2 -> acks at %0d and %0d", ack_c[0], ack_c[1]);

        // Randomized accesses against the model.
        for (int n = 0; n < 300; n++) begin
            logic r_we, r_uns;
            logic [1:0] r_size;
            logic [11:0] r_addr;
            r_we   = 1'($urandom);
            r_uns  = 1'($urandom);
            r_size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0)
                r_addr = 12'($urandom);
            else
                r_addr = 12'($urandom_range(0, 135));
            if (($urandom_range(0, 3) != 0) && (r_size != 2'd3))
                r_addr = r_addr & ~((12'd1 << r_size) - 12'd1);
            run_model_txn($sformatf("rnd%0d", n), r_we, r_size, r_uns, r_addr, $urandom);
        end

        for (int i = 0; i < DEPTH; i++)
            chk($sformatf("final mem word%0d", i), mem[i], ref_mem[i]);
        chk("dm_wren mirrors dm_dmwr", 32'(wren_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
Sequencer placed between the CPU load/store stage and the word-only data memory.
- Accepts byte, halfword and word loads/stores over a req/ack handshake.
- Converts sub-word stores into read-modify-write sequences on the memory's single read/write port.
- Extracts sub-word loads and sign- or zero-extends them.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
DEPTH_WORDS, 32, number of implemented memory words; word index addr[11:2] >= DEPTH_WORDS is out of range.

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous active-high reset
req  in  1  access request; held until ack
we  in  1  1=store, 0=load
size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as error)
uns  in  1  load zero-extend (lbu/lhu); ignored for word loads and stores
addr  in  12  byte address
wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
ack  out  1  one-cycle completion pulse
err  out  1  valid with ack; access rejected
rdata  out  32  load result, valid with ack when !err
dm_dmwr  out  1  memory read/write select: 1=write, 0=read
dm_wren  out  1  mirrors dm_dmwr
dm_address  out  10  memory word address [11:2]
dm_din  out  32  memory write data
dm_dout  in  32  memory read data, valid the cycle after a read-address cycle

Behaviour:
- The clock and reset ports are named clk and rst. Reset is synchronous, active-high; the design has one clock.
- Reset state: IDLE. ack=0, err=0, rdata=0, dm_dmwr=0, dm_wren=0, dm_address=0, dm_din=0.
- All memory-side outputs are registered. dm_dmwr changes only at posedge and is 1 only during the WR state.
  - Reason: memory also reacts to a falling dm_dmwr, so the signal must be glitch-free.
- Byte order is big-endian. Byte offset 0 maps to [31:24]; half offset 0 maps to [31:16].
- Error conditions are checked in IDLE:
  - size==11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr[11:2] >= DEPTH_WORDS
- States:
  - IDLE: if req, latch we/size/uns/addr/wdata.
    - Error -> ERR.
    - Word store -> WR.
    - Otherwise -> RD.
  - RD: dm_address=latched addr[11:2], dm_dmwr=0. Next: LOAD if a load, MERGE if a store.
  - LOAD: dm_dout valid. rdata=extracted lane, extended per uns. ack=1. Next IDLE.
  - MERGE: build merged word = dm_dout with the addressed lane replaced by wdata. Next WR.
  - WR: dm_dmwr=1, dm_din=merged word (or wdata for word store). ack=1. Next IDLE.
  - ERR: ack=1, err=1, no memory access. Next IDLE.
- Latency (req sampled in cycle 0, ack cycle):
  - Word store: ack in cycle 1.
  - Any load: ack in cycle 2.
  - Sub-word store: ack in cycle 3.
  - Error: ack in cycle 1.
- Handshake rules:
  - Request is captured in the IDLE cycle only. Changing or dropping req/inputs after capture does not affect the access in flight.
  - req sampled during non-IDLE states, including the ack cycle, is ignored. A held req is re-accepted in the following IDLE cycle, so back-to-back word stores complete every 2 cycles.
  - ack never asserts for two consecutive cycles.
- rdata holds its last value until the next load ack; stores and errors do not change it.
- Reset mid-operation: state returns to IDLE and dm_dmwr=0 from the next cycle.
  - A store reset before WR performs no memory write.
  - No ack is produced for the aborted access.

Decomposition:
- Shared package dm_access_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum (IDLE, RD, LOAD, MERGE, WR, ERR)
- Sub-module dm_lane_merge, combinational:
  - Inputs: word, addr[1:0], size, wdata, uns.
  - Outputs: merged store word and extended load value.
  - Reused by any future cache or DMA path.

Test Plan:
1. Reset, then sw 0xDEADBEEF @0x010 -> dm_dmwr=1 for exactly cycle 1, dm_address=4, ack cycle 1. Then lw @0x010 -> ack cycle 2, rdata=0xDEADBEEF, err=0.
2. sb 0x...A5 @0x013 -> ack cycle 3, memory word 4 = 0xDEADBEA5. Then lb @0x013 -> rdata=0xFFFFFFA5; lbu @0x013 -> rdata=0x000000A5.
3. sh 0x1234 @0x010 -> word 4 = 0x1234BEA5. Then lh @0x012 -> 0xFFFFBEA5; lhu @0x010 -> 0x00001234.
4. lw @0x012, sh @0x011, sw @0x080 (word 32), size=11 -> each gives ack+err in cycle 1, dm_dmwr never 1, rdata unchanged.
5. sb @0x014 with rst pulsed during MERGE -> no dm_dmwr pulse, no ack, word 5 unchanged. Next lw served with normal latency.
6. req held high across two sw (0x1 @0x000, 0x2 @0x004; inputs switched after first ack) -> acks 2 cycles apart, both words written. Separately, req dropped the cycle after capture -> access still completes with ack.
